eth_tx_sequencer: RTL and testbench

//  Frame sequencer for the Ethernet TX path. Drains one frame of i_len bytes from the TX byte FIFO
//  and emits a byte stream: preamble, SFD, payload, optional pad, 4-byte FCS, then the inter-frame gap.

---
 rtl/eth_pkg.sv | 38 +++
 rtl/eth_tx_sequencer_if.sv | 30 +++
 rtl/crc32.sv | 27 ++
 rtl/eth_tx_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_eth_tx_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, framing constants and CRC-32 step
// for the Ethernet TX path.
package eth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int DEF_LEN_W        = 11;
  localparam int DEF_PREAMBLE_LEN = 7;
  localparam int DEF_MIN_PAYLOAD  = 60;
  localparam int DEF_IFG_CYCLES   = 12;

  // Reflected IEEE 802.3 polynomial, data consumed LSB first.
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_sequencer_if.sv
// eth_tx_sequencer_if: FIFO-side pop and PHY-side valid/ready byte stream.
// master is the sequencer view, slave the FIFO/serializer view.
interface eth_tx_sequencer_if;

  logic       i_fifo_empty;
  logic [7:0] i_fifo_data;
  logic       o_fifo_rd;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_tx_ready,
    output o_fifo_rd,
    output o_tx_data,
    output o_tx_valid
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    output i_tx_ready,
    input  o_fifo_rd,
    input  o_tx_data,
    input  o_tx_valid
  );

endinterface

// File: rtl/crc32.sv
// crc32: byte-wide Ethernet FCS generator; crc is the final
// (inverted) FCS of all bytes accepted since the last reset.
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  assign crc_d = crc32_byte(crc_q, data_in);
  assign crc   = ~crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '1;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/eth_tx_sequencer.sv
// eth_tx_sequencer: frames FIFO payload as preamble/SFD/data/FCS + IFG.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_PAYLOAD.
module eth_tx_sequencer
  import eth_pkg::*;
#(
  parameter int LEN_W        = DEF_LEN_W,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
`ifdef ETH_TX_PAD_EN
  parameter int MIN_PAYLOAD  = DEF_MIN_PAYLOAD,
`endif
  parameter int IFG_CYCLES   = DEF_IFG_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_underrun,
  eth_tx_sequencer_if.master bus
);

  localparam int CNT_MAX =
    (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 4);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);

  state_e             state_q;
  state_e             data_last_st;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   byte_cnt_q;
  logic [LEN_W-1:0]   byte_cnt_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               busy_q;
  logic               done_q;
  logic               under_q;

  logic               xfer;
  logic               crc_clr;
  logic               crc_en;
  logic [7:0]         crc_din;
  logic [31:0]        crc;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               fifo_rd;

  assign byte_cnt_d = byte_cnt_q + LEN_W'(1);
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign crc_clr    = (state_q == S_IDLE) && i_start
                      && (i_len != '0);

`ifdef ETH_TX_PAD_EN
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_PAYLOAD);
  assign data_last_st = (len_q < MIN_LEN) ? S_PAD : S_FCS;
`else
  assign data_last_st = S_FCS;
`endif

  crc32 u_crc (
    .clk     (clk),
    .rst     (rst | crc_clr),
    .en      (crc_en),
    .data_in (crc_din),
    .crc     (crc)
  );

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    fifo_rd  = 1'b0;
    crc_en   = 1'b0;
    crc_din  = '0;
    unique case (state_q)
      S_PRE: begin
        tx_valid = 1'b1;
        tx_data  = PREAMBLE_BYTE;
      end
      S_SFD: begin
        tx_valid = 1'b1;
        tx_data  = SFD_BYTE;
      end
      S_DATA: begin
        tx_valid = !bus.i_fifo_empty;
        tx_data  = bus.i_fifo_data;
        fifo_rd  = !bus.i_fifo_empty && bus.i_tx_ready;
        crc_en   = fifo_rd;
        crc_din  = bus.i_fifo_data;
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        tx_valid = 1'b1;
        crc_en   = bus.i_tx_ready;
      end
`endif
      S_FCS: begin
        tx_valid = 1'b1;
        tx_data  = crc[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign xfer = tx_valid && bus.i_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      under_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (crc_clr) begin
            len_q      <= i_len;
            byte_cnt_q <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_PRE;
          end
        end
        S_PRE: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (cnt_q == PRE_LAST) begin
              cnt_q   <= '0;
              state_q <= S_SFD;
            end
          end
        end
        S_SFD: begin
          if (xfer) state_q <= S_DATA;
        end
        S_DATA: begin
          // An empty FIFO mid-payload aborts; no FCS follows.
          if (bus.i_fifo_empty) begin
            under_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IFG;
          end else if (xfer) begin
            byte_cnt_q <= byte_cnt_d;
            if (byte_cnt_d == len_q) state_q <= data_last_st;
          end
        end
`ifdef ETH_TX_PAD_EN
        S_PAD: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_d;
            if (byte_cnt_d == MIN_LEN) state_q <= S_FCS;
          end
        end
`endif
        S_FCS: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (cnt_q == FCS_LAST) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_IFG;
            end
          end
        end
        S_IFG: begin
          cnt_q <= cnt_d;
          if (cnt_q == IFG_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_underrun     = under_q;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_fifo_rd  = fifo_rd;

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// tb_eth_tx_sequencer: scoreboard bench; stimulus queues expected bytes,
// a negedge monitor pops and compares every accepted output byte.
module tb_eth_tx_sequencer;

  typedef logic [7:0] bq_t[$];

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        i_start = 1'b0;
  logic [10:0] i_len   = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_underrun;

  eth_tx_sequencer_if bus ();

  eth_tx_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_underrun (o_underrun),
    .bus        (bus)
  );

  always #5 clk = ~clk;

`ifdef ETH_TX_PAD_EN
  localparam bit HAND = 1'b0;
`else
  localparam bit HAND = 1'b1;
`endif

  int   errors = 0;
  int   checks = 0;
  bq_t  exp_q;
  int   exp_rd = 0;
  bq_t  fifo_q;
  int   rd_ptr = 0;
  logic ready_tgl = 1'b0;
  logic held = 1'b0;
  logic [7:0] held_d = '0;
  logic [7:0] e;
  logic rd;
  bq_t  p;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Independent reference: MSB-first register, bits fed LSB first,
  // result reflected and inverted.
  function automatic logic [31:0] ref_fcs(input bq_t b);
    logic [31:0] r;
    logic [31:0] o;
    logic        fb;
    r = 32'hFFFF_FFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = r[31] ^ b[k][i];
        r  = r << 1;
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    end
    for (int i = 0; i < 32; i++) o[i] = ~r[31-i];
    return o;
  endfunction

  // FIFO model (first-word-fall-through) and sink ready generator.
  always @(posedge clk) begin
    rd = bus.o_fifo_rd;
    #1;
    if (rd) rd_ptr++;
    bus.i_fifo_empty = (rd_ptr >= fifo_q.size());
    bus.i_fifo_data  = bus.i_fifo_empty ? 8'h00 : fifo_q[rd_ptr];
    bus.i_tx_ready   = ready_tgl ? ~bus.i_tx_ready : 1'b1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && bus.o_tx_valid)
        chk("hold", {24'h0, bus.o_tx_data}, {24'h0, held_d});
      held   = bus.o_tx_valid && !bus.i_tx_ready;
      held_d = bus.o_tx_data;
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (exp_rd >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h required none",
                   bus.o_tx_data);
        end else begin
          e = exp_q[exp_rd];
          exp_rd++;
          chk("byte", {24'h0, bus.o_tx_data}, {24'h0, e});
        end
      end
      if (o_done) chk("done_drained", exp_q.size() - exp_rd, 0);
    end
  end

  task automatic load(input bq_t b);
    @(negedge clk);
    foreach (b[k]) fifo_q.push_back(b[k]);
  endtask

  task automatic push_frame(input bq_t b, input int nfcs,
                            input bit use_hand,
                            input logic [31:0] hand);
    bq_t         body;
    logic [31:0] f;
    body = b;
`ifdef ETH_TX_PAD_EN
    if (nfcs > 0)
      while (body.size() < 60) body.push_back(8'h00);
`endif
    f = use_hand ? hand : ref_fcs(body);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[k]) exp_q.push_back(body[k]);
    for (int i = 0; i < nfcs; i++) exp_q.push_back(f[8*i +: 8]);
  endtask

  task automatic start(input logic [10:0] len);
    @(negedge clk);
    i_start = 1'b1;
    i_len   = len;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_rise", {31'h0, o_busy}, 1);
  endtask

  task automatic run_frame(input string nm, input int exp_done,
                           input int exp_under, input int inj_len);
    int ifg;
    int nd;
    int nu;
    bit seen;
    bit ok;
    ifg  = 0;
    nd   = 0;
    nu   = 0;
    seen = 1'b0;
    ok   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (o_done) nd++;
      if (o_underrun) begin
        nu++;
        chk({nm, "_urun_valid"}, {31'h0, bus.o_tx_valid}, 0);
      end
      if (o_done || o_underrun) seen = 1'b1;
      if (seen && o_busy) ifg++;
      i_start = (inj_len >= 0) && o_done;
      i_len   = 11'(inj_len);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    chk({nm, "_finish"}, {31'h0, ok}, 1);
    chk({nm, "_ifg"}, ifg, 12);
    chk({nm, "_done"}, nd, exp_done);
    chk({nm, "_underrun"}, nu, exp_under);
    chk({nm, "_drained"}, exp_q.size() - exp_rd, 0);
  endtask

  initial begin
    bit ok;
    bit busy_seen;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, bus.o_tx_valid}, 0);
    chk("rst_data", {24'h0, bus.o_tx_data}, 0);
    chk("rst_busy", {31'h0, o_busy}, 0);
    chk("rst_done", {31'h0, o_done}, 0);
    chk("rst_urun", {31'h0, o_underrun}, 0);
    chk("rst_fifo_rd", {31'h0, bus.o_fifo_rd}, 0);
    rst = 1'b0;

    p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load(p);
    push_frame(p, 4, 1'b0, 32'h0);
    start(11'd4);
    run_frame("len4", 1, 0, -1);

    p = {};
    for (int i = 0; i < 64; i++) p.push_back(8'(i * 7 + 3));
    load(p);
    push_frame(p, 4, 1'b0, 32'h0);
    start(11'd64);
    run_frame("len64", 1, 0, -1);

    @(negedge clk);
    ready_tgl = 1'b1;
    p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load(p);
    push_frame(p, 4, 1'b0, 32'h0);
    start(11'd4);
    run_frame("toggle", 1, 0, -1);
    ready_tgl = 1'b0;
    repeat (2) @(negedge clk);

    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
          8'h36, 8'h37, 8'h38, 8'h39};
    load(p);
    push_frame(p, 4, HAND, 32'hCBF4_3926);
    start(11'd9);
    run_frame("check9", 1, 0, -1);

    p = '{8'h11, 8'h22, 8'h33};
    load(p);
    push_frame(p, 0, 1'b0, 32'h0);
    start(11'd10);
    run_frame("urun", 0, 1, -1);

    @(negedge clk);
    i_start = 1'b1;
    i_len   = 11'd0;
    @(negedge clk);
    i_start = 1'b0;
    chk("len0_busy", {31'h0, o_busy}, 0);
    repeat (3) @(negedge clk);
    chk("len0_idle", {31'h0, o_busy}, 0);
    chk("len0_valid", {31'h0, bus.o_tx_valid}, 0);

    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(p);
    push_frame(p, 4, 1'b0, 32'h0);
    start(11'd4);
    run_frame("ifg_start", 1, 0, 5);
    busy_seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      busy_seen = busy_seen | o_busy;
    end
    chk("ifg_start_ignored", {31'h0, busy_seen}, 0);

    p = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
    load(p);
    push_frame(p, 2, 1'b0, 32'h0);
    start(11'd4);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      #1;
      if (exp_rd == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_reach_fcs2", {31'h0, ok}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'h0, bus.o_tx_valid}, 0);
    chk("midrst_busy", {31'h0, o_busy}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    p = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    load(p);
    push_frame(p, 4, 1'b0, 32'h0);
    start(11'd4);
    run_frame("after_rst", 1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
